// File: rtl/nn_sequencer_if.sv
// nn_sequencer_if: host, per-layer handshake/bus and SDRAM master signals of the sequencer
// master: sequencer side (drives ready/grant returns/m_* requests); slave: environment side
interface nn_sequencer_if;
  logic        start, busy, done, error;
  logic [31:0] toHexLed;
  logic        l1_ready, l2_ready, l3_ready;
  logic        l1_done, l2_done, l3_done;
  logic        l1_read_n, l2_read_n, l3_read_n;
  logic        l1_write_n, l2_write_n, l3_write_n;
  logic [31:0] l1_address, l2_address, l3_address;
  logic [15:0] l1_writedata, l2_writedata, l3_writedata;
  logic        l1_waitrequest, l2_waitrequest, l3_waitrequest;
  logic        l1_readdatavalid, l2_readdatavalid, l3_readdatavalid;
  logic [15:0] l1_readdata, l2_readdata, l3_readdata;
  logic        m_waitrequest, m_readdatavalid;
  logic [15:0] m_readdata;
  logic        m_read_n, m_write_n;
  logic [31:0] m_address;
  logic [15:0] m_writedata;
  logic        m_chipselect;
  logic [1:0]  m_byteenable;
  modport master (
    input  start, l1_done, l2_done, l3_done,
           l1_read_n, l2_read_n, l3_read_n, l1_write_n, l2_write_n, l3_write_n,
           l1_address, l2_address, l3_address, l1_writedata, l2_writedata, l3_writedata,
           m_waitrequest, m_readdatavalid, m_readdata,
    output busy, done, error, toHexLed, l1_ready, l2_ready, l3_ready,
           l1_waitrequest, l2_waitrequest, l3_waitrequest,
           l1_readdatavalid, l2_readdatavalid, l3_readdatavalid,
           l1_readdata, l2_readdata, l3_readdata,
           m_read_n, m_write_n, m_address, m_writedata, m_chipselect, m_byteenable
  );
  modport slave (
    output start, l1_done, l2_done, l3_done,
           l1_read_n, l2_read_n, l3_read_n, l1_write_n, l2_write_n, l3_write_n,
           l1_address, l2_address, l3_address, l1_writedata, l2_writedata, l3_writedata,
           m_waitrequest, m_readdatavalid, m_readdata,
    input  busy, done, error, toHexLed, l1_ready, l2_ready, l3_ready,
           l1_waitrequest, l2_waitrequest, l3_waitrequest,
           l1_readdatavalid, l2_readdatavalid, l3_readdatavalid,
           l1_readdata, l2_readdata, l3_readdata,
           m_read_n, m_write_n, m_address, m_writedata, m_chipselect, m_byteenable
  );
endinterface

// File: rtl/nn_sequencer.sv
// nn_sequencer: runs layers 1..3 in order via ready/done handshakes and muxes the granted layer onto the SDRAM master
// ports: clk, reset (sync, active-high), bus (nn_sequencer_if.master); optional watchdog enabled by SEQ_TIMEOUT_EN
module nn_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_000_000
) (
  input logic             clk,
  input logic             reset,
  nn_sequencer_if.master  bus
);
  typedef enum logic [3:0] {IDLE, RUN_L1, DROP_L1, RUN_L2, DROP_L2, RUN_L3, DROP_L3, DONE, ERROR} state_e;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  ready_q, ld;
  logic        busy_q, done_q, error_q, tmo;
  logic [1:0]  gnt;
  assign ld = {bus.l3_done, bus.l2_done, bus.l1_done};
`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        run;
  assign run = state_q inside {RUN_L1, RUN_L2, RUN_L3};
  assign tmo = run && wd_q == TIMEOUT_CYCLES - 32'd1;
  always_ff @(posedge clk)
    if (reset || state_d != state_q) wd_q <= '0;
    else if (run) wd_q <= wd_q + 32'd1;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? RUN_L1 : IDLE;
      RUN_L1:  state_d = tmo ? ERROR : ld[0] ? DROP_L1 : RUN_L1;
      DROP_L1: state_d = ld[0] ? DROP_L1 : RUN_L2;
      RUN_L2:  state_d = tmo ? ERROR : ld[1] ? DROP_L2 : RUN_L2;
      DROP_L2: state_d = ld[1] ? DROP_L2 : RUN_L3;
      RUN_L3:  state_d = tmo ? ERROR : ld[2] ? DROP_L3 : RUN_L3;
      DROP_L3: state_d = ld[2] ? DROP_L3 : DONE;
      DONE:    state_d = bus.start ? DONE : IDLE;
      ERROR:   state_d = bus.start ? ERROR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cnt_d = (state_q == IDLE && state_d == RUN_L1) ? '0 :
                 (busy_q && ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= {state_d == RUN_L3, state_d == RUN_L2, state_d == RUN_L1};
      busy_q  <= state_d inside {RUN_L1, DROP_L1, RUN_L2, DROP_L2, RUN_L3, DROP_L3};
      done_q  <= state_d == DONE;
      error_q <= state_d == ERROR;
      cnt_q   <= cnt_d;
    end
  end
  assign gnt = (state_q == RUN_L1 || state_q == DROP_L1) ? 2'd1 :
               (state_q == RUN_L2 || state_q == DROP_L2) ? 2'd2 :
               (state_q == RUN_L3 || state_q == DROP_L3) ? 2'd3 : 2'd0;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.toHexLed = {cnt_q[27:0], state_q};
  assign bus.l1_ready = ready_q[0];
  assign bus.l2_ready = ready_q[1];
  assign bus.l3_ready = ready_q[2];
  // a simultaneous read+write request is forwarded as a write only
  assign bus.m_read_n = gnt == 2'd1 ? (bus.l1_read_n | ~bus.l1_write_n) :
                        gnt == 2'd2 ? (bus.l2_read_n | ~bus.l2_write_n) :
                        gnt == 2'd3 ? (bus.l3_read_n | ~bus.l3_write_n) : 1'b1;
  assign bus.m_write_n = gnt == 2'd1 ? bus.l1_write_n : gnt == 2'd2 ? bus.l2_write_n :
                         gnt == 2'd3 ? bus.l3_write_n : 1'b1;
  assign bus.m_address = gnt == 2'd1 ? bus.l1_address : gnt == 2'd2 ? bus.l2_address :
                         gnt == 2'd3 ? bus.l3_address : '0;
  assign bus.m_writedata = gnt == 2'd1 ? bus.l1_writedata : gnt == 2'd2 ? bus.l2_writedata :
                           gnt == 2'd3 ? bus.l3_writedata : '0;
  assign bus.m_chipselect = 1'b1;
  assign bus.m_byteenable = 2'b11;
  assign bus.l1_waitrequest   = gnt == 2'd1 ? bus.m_waitrequest : 1'b1;
  assign bus.l2_waitrequest   = gnt == 2'd2 ? bus.m_waitrequest : 1'b1;
  assign bus.l3_waitrequest   = gnt == 2'd3 ? bus.m_waitrequest : 1'b1;
  assign bus.l1_readdatavalid = gnt == 2'd1 && bus.m_readdatavalid;
  assign bus.l2_readdatavalid = gnt == 2'd2 && bus.m_readdatavalid;
  assign bus.l3_readdatavalid = gnt == 2'd3 && bus.m_readdatavalid;
  assign bus.l1_readdata = bus.m_readdata;
  assign bus.l2_readdata = bus.m_readdata;
  assign bus.l3_readdata = bus.m_readdata;
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: scoreboard bench for nn_sequencer; expected ready order queued at start, popped on ready rises
module tb_nn_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  int   n_chk = 0, n_fail = 0;
  int   exp_q[$];
  logic [2:0] prev_rdy = '0;
  nn_sequencer_if bus();
  nn_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic rdy(input int k);
    return k == 1 ? bus.l1_ready : k == 2 ? bus.l2_ready : bus.l3_ready;
  endfunction
  task automatic set_done(input int k, input logic v);
    if (k == 1) bus.l1_done = v;
    else if (k == 2) bus.l2_done = v;
    else bus.l3_done = v;
  endtask
  task automatic wait_sig(input int k, input logic v);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rdy(k) == v) return;
    end
    check($sformatf("wait_l%0d_ready", k), {31'd0, rdy(k)}, {31'd0, v});
  endtask
  task automatic finish_layer(input int k, input int hold);
    set_done(k, 1'b1);
    wait_sig(k, 1'b0);
    for (int i = 0; i < hold; i++) begin
      check($sformatf("drop_l%0d_hold", k), {28'd0, bus.toHexLed[3:0]}, 32'(2 * k));
      @(negedge clk);
    end
    set_done(k, 1'b0);
  endtask
  task automatic serve(input int k, input int lat, input int hold);
    wait_sig(k, 1'b1);
    repeat (lat) @(negedge clk);
    finish_layer(k, hold);
  endtask
  always @(negedge clk) begin
    logic [2:0] r, rise;
    r = {bus.l3_ready, bus.l2_ready, bus.l1_ready};
    rise = r & ~prev_rdy;
    prev_rdy = r;
    if (r != 3'd0) check("ready_onehot", $countones(r), 1);
    if (rise != 3'd0) begin
      if (exp_q.size() == 0) check("unexp_ready", {29'd0, rise}, 0);
      else check("ready_order", {29'd0, rise}, 32'd1 << (exp_q.pop_front() - 1));
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end
  initial begin
    bus.start = 0; bus.l1_done = 0; bus.l2_done = 0; bus.l3_done = 0;
    bus.l1_read_n = 1; bus.l2_read_n = 1; bus.l3_read_n = 1;
    bus.l1_write_n = 1; bus.l2_write_n = 1; bus.l3_write_n = 1;
    bus.l1_address = 0; bus.l2_address = 0; bus.l3_address = 0;
    bus.l1_writedata = 0; bus.l2_writedata = 0; bus.l3_writedata = 0;
    bus.m_waitrequest = 0; bus.m_readdatavalid = 0; bus.m_readdata = 0;
    repeat (3) @(negedge clk);
    check("rst_hex", bus.toHexLed, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_error", {31'd0, bus.error}, 0);
    check("rst_m_read_n", {31'd0, bus.m_read_n}, 1);
    check("rst_m_write_n", {31'd0, bus.m_write_n}, 1);
    check("rst_cs_be", {29'd0, bus.m_chipselect, bus.m_byteenable}, 32'h7);
    bus.start = 1;
    @(negedge clk);
    check("rst_over_start", {28'd0, bus.toHexLed[3:0]}, 0);
    bus.l1_read_n = 0; bus.l1_address = 32'd800;
    #1 check("idle_no_grant", bus.m_address, 0);
    bus.l1_read_n = 1; bus.l1_address = 0;
    // full run, start held high through DONE
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    reset = 0;
    wait_sig(1, 1'b1);
    check("run_l1_busy", {31'd0, bus.busy}, 1);
    bus.l2_done = 1; bus.l3_done = 1;
    repeat (3) @(negedge clk);
    check("ignore_done", {28'd0, bus.toHexLed[3:0]}, 1);
    bus.l2_done = 0; bus.l3_done = 0;
    repeat (47) @(negedge clk);
    finish_layer(1, 0);
    serve(2, 50, 0);
    serve(3, 50, 0);
    @(negedge clk);
    check("done_hex", bus.toHexLed, {28'd156, 4'd7});
    check("done_flag", {31'd0, bus.done}, 1);
    check("done_busy", {31'd0, bus.busy}, 0);
    repeat (10) @(negedge clk);
    check("done_held", {31'd0, bus.done}, 1);
    check("done_state_held", {28'd0, bus.toHexLed[3:0]}, 7);
    bus.start = 0;
    @(negedge clk);
    check("back_idle", bus.toHexLed, {28'd156, 4'd0});
    check("idle_done", {31'd0, bus.done}, 0);
    // bus arbitration and prolonged done
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    bus.start = 1;
    serve(1, 10, 0);
    bus.start = 0;
    wait_sig(2, 1'b1);
    bus.l1_read_n = 0; bus.l1_address = 32'd800;
    bus.m_waitrequest = 1; bus.m_readdatavalid = 1; bus.m_readdata = 16'hBEEF;
    #1;
    check("l1_blk_read_n", {31'd0, bus.m_read_n}, 1);
    check("l1_blk_addr", bus.m_address, 0);
    check("l1_wait", {31'd0, bus.l1_waitrequest}, 1);
    check("l1_rdv", {31'd0, bus.l1_readdatavalid}, 0);
    check("l2_rdv", {31'd0, bus.l2_readdatavalid}, 1);
    check("l3_rdata", {16'd0, bus.l3_readdata}, 32'hBEEF);
    bus.l2_read_n = 0; bus.l2_address = 32'd300_000; bus.m_waitrequest = 0;
    #1;
    check("l2_read_n", {31'd0, bus.m_read_n}, 0);
    check("l2_addr", bus.m_address, 32'd300_000);
    check("l2_wait", {31'd0, bus.l2_waitrequest}, 0);
    check("l1_wait_hold", {31'd0, bus.l1_waitrequest}, 1);
    bus.l2_write_n = 0; bus.l2_writedata = 16'h1234;
    #1;
    check("rw_read_n", {31'd0, bus.m_read_n}, 1);
    check("rw_write_n", {31'd0, bus.m_write_n}, 0);
    check("rw_wdata", {16'd0, bus.m_writedata}, 32'h1234);
    bus.l1_read_n = 1; bus.l1_address = 0; bus.l2_read_n = 1; bus.l2_write_n = 1;
    bus.l2_address = 0; bus.l2_writedata = 0; bus.m_readdatavalid = 0;
    repeat (20) @(negedge clk);
    finish_layer(2, 5);
    @(negedge clk);
    check("l3_after_drop", {31'd0, bus.l3_ready}, 1);
    check("run_l3_state", {28'd0, bus.toHexLed[3:0]}, 5);
    serve(3, 10, 0);
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 1);
    @(negedge clk);
    // reset mid-transfer in RUN_L3
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    bus.start = 1;
    serve(1, 5, 0);
    bus.start = 0;
    serve(2, 5, 0);
    wait_sig(3, 1'b1);
    bus.l3_read_n = 0; bus.l3_address = 32'h40;
    #1 check("l3_read_n", {31'd0, bus.m_read_n}, 0);
    reset = 1;
    @(negedge clk);
    check("mid_rst_hex", bus.toHexLed, 0);
    check("mid_rst_l3_ready", {31'd0, bus.l3_ready}, 0);
    check("mid_rst_read_n", {31'd0, bus.m_read_n}, 1);
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    reset = 0; bus.l3_read_n = 1; bus.l3_address = 0;
    @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
    exp_q.push_back(1);
    bus.start = 1;
    wait_sig(1, 1'b1);
    repeat (99) @(negedge clk);
    check("wd_before", {28'd0, bus.toHexLed[3:0]}, 1);
    @(negedge clk);
    check("wd_error_state", {28'd0, bus.toHexLed[3:0]}, 8);
    check("wd_error", {31'd0, bus.error}, 1);
    check("wd_busy", {31'd0, bus.busy}, 0);
    check("wd_ready", {31'd0, bus.l1_ready}, 0);
    check("wd_read_n", {31'd0, bus.m_read_n}, 1);
    bus.start = 0;
    @(negedge clk);
    check("wd_idle", {28'd0, bus.toHexLed[3:0]}, 0);
    check("wd_error_clr", {31'd0, bus.error}, 0);
`endif
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
